l2_arbiter: RTL
===============

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter LINE_W, default 256, SHALL set the cache-line data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-005 i_read  in  1  SHALL be the I-cache line-read request, held until i_resp.
REQ-006 i_address  in  ADDR_W  SHALL be the I-cache line address.
REQ-007 i_rdata  out  LINE_W  SHALL be the line returned to the I-cache.
REQ-008 i_resp  out  1  SHALL be the one-cycle I-cache completion pulse.
REQ-009 d_read, d_write  in  1 each  SHALL be the D-cache line-read and line-write requests, mutually exclusive, held until d_resp.
REQ-010 d_address  in  ADDR_W  SHALL be the D-cache line address.
REQ-011 d_wdata  in  LINE_W  SHALL be the D-cache writeback line.
REQ-012 d_rdata  out  LINE_W  SHALL be the line returned to the D-cache.
REQ-013 d_resp  out  1  SHALL be the one-cycle D-cache completion pulse.
REQ-014 l2_read, l2_write  out  1 each  SHALL be the downstream read and write strobes to L2/prefetch control.
REQ-015 l2_address  out  ADDR_W  SHALL be the downstream address.
REQ-016 l2_wdata  out  LINE_W  SHALL be the downstream write line.
REQ-017 l2_rdata  in  LINE_W  SHALL be the downstream returned line.
REQ-018 l2_resp  in  1  SHALL be the downstream completion pulse.
REQ-019 i_grants, d_grants  out  16 each  SHALL be saturating grant counters.

Function
REQ-020 FSM states SHALL be IDLE, SERVE_I and SERVE_D.
REQ-021 IDLE, only i_read pending: go to SERVE_I; only d_read|d_write pending: go to SERVE_D; neither pending: stay in IDLE.
REQ-022 IDLE, both pending: grant the side opposite last_grant; last_grant SHALL update on every grant.
REQ-023 On grant, the requester's address, and the read/write type for D, SHALL be latched; l2_address SHALL come from the latch during SERVE_*.
REQ-024 SERVE_I: l2_read=1, l2_write=0.
REQ-025 SERVE_D: l2_read=d_read latch, l2_write=d_write latch; l2_wdata=d_wdata passthrough.
REQ-026 In IDLE, l2_read=l2_write=0 and no downstream request SHALL be issued; request-to-l2_read latency SHALL be exactly 1 cycle.
REQ-027 In SERVE_x with l2_resp=1: x_resp=1 combinationally in the same cycle, x_rdata=l2_rdata, next state IDLE.
REQ-028 The opposite side's resp SHALL never assert; i_rdata and d_rdata SHALL pass l2_rdata at all times.
REQ-029 A requester dropping its request mid-serve SHALL NOT abort the transaction; the arbiter holds until l2_resp and still pulses resp.
REQ-030 l2_resp in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-031 Each grant SHALL increment its counter by 1, saturating at 16'hFFFF (no wrap).
REQ-032 The cycle after a resp, the arbiter SHALL be in IDLE and re-arbitrate on current inputs; back-to-back service SHALL occur with one idle cycle between transactions.

Reset
REQ-033 reset=0 SHALL asynchronously force state=IDLE, last_grant=I (so D wins the first tie), latches=0, counters=0, all outputs strobes/resps=0.
REQ-034 Reset asserted mid-serve SHALL drop the downstream strobe immediately; any later l2_resp SHALL be ignored.
REQ-035 Reset deassertion SHALL take effect at the next rising clk edge; the first grant is possible on that edge.

Verification
REQ-036 Single I read, addr 0x100, l2_resp 3 cycles later with data A -> l2_read high 3 cycles, i_resp 1 cycle with i_rdata=A, i_grants=1.
REQ-037 i_read and d_read together after reset -> D served first, then I after one IDLE cycle; d_grants=1, i_grants=1.
REQ-038 Both requests held continuously for 6 transactions -> grant order D,I,D,I,D,I.
REQ-039 d_write addr 0x2A0 with data W -> l2_write=1, l2_read=0, l2_address=0x2A0, l2_wdata=W until l2_resp; d_resp pulses once.
REQ-040 Reset pulsed while in SERVE_I, then stray l2_resp -> strobes 0 within the reset cycle, no i_resp, counters 0.
REQ-041 Preload d_grants to 0xFFFE via 3 more grants -> counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter
// Arbitrates one shared L2 line port between the I-cache (read-only) and the
// D-cache (read or writeback). One transaction is in flight at a time. On a tie
// the side that was not granted last wins. Address and D read/write type are
// captured at grant time. Completion is signalled combinationally from l2_resp.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   i_read, i_address            I-cache line-read request (held until i_resp)
//   i_rdata, i_resp              line returned to I-cache, completion pulse
//   d_read, d_write, d_address   D-cache line request (held until d_resp)
//   d_wdata                      D-cache writeback line
//   d_rdata, d_resp              line returned to D-cache, completion pulse
//   l2_read, l2_write            downstream strobes
//   l2_address, l2_wdata         downstream address and write line
//   l2_rdata, l2_resp            downstream returned line, completion pulse
//   i_grants, d_grants           saturating grant counters
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [15:0]       i_grants,
  output logic [15:0]       d_grants
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {GNT_I, GNT_D} side_e;

  state_e            state_q;
  side_e             last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [15:0]       i_grants_q, i_grants_d;
  logic [15:0]       d_grants_q, d_grants_d;

  logic i_req, d_req, grant_i, grant_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // D wins a tie only if I was granted last; grants only happen from IDLE.
  assign grant_d = (state_q == IDLE) && d_req && (!i_req || (last_grant_q == GNT_I));
  assign grant_i = (state_q == IDLE) && i_req && !grant_d;

  assign i_grants_d = grant_i ? sat_inc(i_grants_q) : i_grants_q;
  assign d_grants_d = grant_d ? sat_inc(d_grants_q) : d_grants_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      i_grants_q   <= '0;
      d_grants_q   <= '0;
    end else begin
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
      case (state_q)
        IDLE: begin
          // l2_resp arriving here is stray and deliberately ignored.
          if (grant_d) begin
            state_q      <= SERVE_D;
            last_grant_q <= GNT_D;
            addr_q       <= d_address;
            l2_read_q    <= d_read;
            l2_write_q   <= d_write;
          end else if (grant_i) begin
            state_q      <= SERVE_I;
            last_grant_q <= GNT_I;
            addr_q       <= i_address;
            l2_read_q    <= 1'b1;
            l2_write_q   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Requester input is not looked at: only l2_resp ends a transaction.
          if (l2_resp) begin
            state_q    <= IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          l2_read_q  <= 1'b0;
          l2_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = d_wdata;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;
  assign i_resp     = (state_q == SERVE_I) && l2_resp;
  assign d_resp     = (state_q == SERVE_D) && l2_resp;
  assign i_grants   = i_grants_q;
  assign d_grants   = d_grants_q;

endmodule
